// File: rtl/pc_pkg.sv
// Shared constants for the program-counter slice: widths, the reset/restart vector
// and the pcSrc select encodings used by the control unit.
package pc_pkg;

    localparam int WIDTH   = 16;
    localparam int PC_STEP = 2;
    localparam logic [WIDTH-1:0] RESET_PC = 16'h0000;

    typedef enum logic [2:0] {
        PC_SEQ     = 3'd0,
        PC_BR_REL  = 3'd1,
        PC_JUMP    = 3'd2,
        PC_RA      = 3'd3,
        PC_MARY    = 3'd4,
        PC_BR_ABS  = 3'd5,
        PC_BR_RA   = 3'd6,
        PC_RESTART = 3'd7
    } pc_src_e;

    // Modulo-2^WIDTH add; the carry out is dropped so addresses wrap silently.
    function automatic logic [WIDTH-1:0] pc_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: sequential, relative/absolute branches,
// register-supplied targets and the restart vector.
module pc_next_mux
    import pc_pkg::*;
(
    input  logic [WIDTH-1:0] pc,
    input  logic [2:0]       pc_src,
    input  logic             comp,
    input  logic [WIDTH-1:0] imm_addr,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] mary,
    output logic [WIDTH-1:0] next_pc
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(PC_STEP);

    pc_src_e          sel;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] rel_pc;

    assign sel    = pc_src_e'(pc_src);
    assign seq_pc = pc_add(pc, STEP_W);
    // imm_addr arrives already sign-extended, so a plain add gives two's-complement offsets.
    assign rel_pc = pc_add(pc, imm_addr);

    always_comb begin
        next_pc = seq_pc;
        case (sel)
            PC_SEQ:     next_pc = seq_pc;
            PC_BR_REL:  next_pc = comp ? rel_pc : seq_pc;
            PC_JUMP:    next_pc = imm_addr;
            PC_RA:      next_pc = ra;
            PC_MARY:    next_pc = mary;
            PC_BR_ABS:  next_pc = comp ? imm_addr : seq_pc;
            PC_BR_RA:   next_pc = comp ? ra : seq_pc;
            PC_RESTART: next_pc = RESET_PC;
            default:    next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_block.sv
// Program-counter register: holds the current instruction address and loads the
// selected next address on write-enabled edges; reset dominates everything.
module pc_block
    import pc_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       pcSrc,
    input  logic [WIDTH-1:0] immAddr,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] mary,
    input  logic             comp,
    input  logic             pcWrite,
    output logic [WIDTH-1:0] pcOut
);

    // Power-up value is defined so pcOut reads zero even before the first reset.
    logic [WIDTH-1:0] pc_q = '0;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] next_pc;

    pc_next_mux u_next (
        .pc       (pc_q),
        .pc_src   (pcSrc),
        .comp     (comp),
        .imm_addr (immAddr),
        .ra       (ra),
        .mary     (mary),
        .next_pc  (next_pc)
    );

    always_comb begin
        pc_d = pc_q;
        if (pcWrite) begin
            pc_d = next_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pcOut = pc_q;

endmodule

// File: tb/tb_pc_block.sv
// Self-checking bench for pc_block: directed plan with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural PC model.
module tb_pc_block;

    logic        clock;
    logic        reset;
    logic [2:0]  pcSrc;
    logic [15:0] immAddr;
    logic [15:0] ra;
    logic [15:0] mary;
    logic        comp;
    logic        pcWrite;
    logic [15:0] pcOut;

    int n_checks = 0;
    int n_fails  = 0;
    int model_pc = 0;

    pc_block dut (
        .clock   (clock),
        .reset   (reset),
        .pcSrc   (pcSrc),
        .immAddr (immAddr),
        .ra      (ra),
        .mary    (mary),
        .comp    (comp),
        .pcWrite (pcWrite),
        .pcOut   (pcOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural reference: the PC as an integer, updated with plain arithmetic.
    function automatic int model_next(int pc, int src, bit c, int imm, int r, int m);
        int nxt;
        case (src)
            0: nxt = pc + 2;
            1: nxt = c ? pc + imm : pc + 2;
            2: nxt = imm;
            3: nxt = r;
            4: nxt = m;
            5: nxt = c ? imm : pc + 2;
            6: nxt = c ? r : pc + 2;
            default: nxt = 0;
        endcase
        return nxt % 65536;
    endfunction

    always @(posedge clock) begin
        if (reset)
            model_pc <= 0;
        else if (pcWrite)
            model_pc <= model_next(model_pc, int'(pcSrc), comp, int'(immAddr), int'(ra), int'(mary));
    end

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: pcOut=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        check("model", pcOut, model_pc[15:0]);
    end

    task automatic step(input bit rst, input bit wr, input logic [2:0] src, input logic [15:0] imm,
                        input logic [15:0] r, input logic [15:0] m, input bit c,
                        input string name, input logic [15:0] expected);
        @(negedge clock);
        reset = rst; pcWrite = wr; pcSrc = src; immAddr = imm; ra = r; mary = m; comp = c;
        @(posedge clock);
        #1;
        check(name, pcOut, expected);
        $display("txn %-10s rst=%0d wr=%0d src=%0d imm=%h ra=%h mary=%h comp=%0d -> pcOut=%h",
                 name, rst, wr, src, imm, r, m, c, pcOut);
    endtask

    initial begin
        logic [15:0] seq_exp [5];
        seq_exp = '{16'd4, 16'd6, 16'd8, 16'd10, 16'd12};
        reset = 1'b0; pcWrite = 1'b0; pcSrc = 3'd0; immAddr = '0; ra = '0; mary = '0; comp = 1'b0;
        #1;
        check("powerup", pcOut, 16'h0000);

        for (int i = 0; i < 5; i++) step(1, 1, 3'd2, 16'h1234, 0, 0, 0, "reset", 16'h0000);
        for (int i = 0; i < 5; i++) step(0, 0, 3'd2, 16'h1234, 0, 0, 0, "hold", 16'h0000);

        step(0, 1, 3'd2, 16'h0002, 0, 0, 0, "jump", 16'h0002);
        for (int i = 0; i < 5; i++) step(0, 1, 3'd0, 16'h0000, 0, 0, 0, "seq", seq_exp[i]);

        step(0, 1, 3'd3, 16'h0000, 16'd3, 16'd4, 0, "ra", 16'h0003);
        step(0, 1, 3'd4, 16'h0000, 16'd3, 16'd4, 0, "mary", 16'h0004);
        step(0, 1, 3'd7, 16'h0000, 16'd3, 16'd4, 0, "restart", 16'h0000);

        for (int s = 0; s < 3; s++) begin
            logic [2:0] src;
            src = (s == 0) ? 3'd1 : (s == 1) ? 3'd5 : 3'd6;
            step(0, 1, 3'd2, 16'h0010, 0, 0, 0, "setpc", 16'h0010);
            step(0, 1, src, 16'h0008, 16'h0100, 0, 0, "br_nt", 16'h0012);
        end
        step(0, 1, 3'd2, 16'h0010, 0, 0, 0, "setpc", 16'h0010);
        step(0, 1, 3'd1, 16'h0008, 16'h0100, 0, 1, "br_rel", 16'h0018);
        step(0, 1, 3'd2, 16'h0010, 0, 0, 0, "setpc", 16'h0010);
        step(0, 1, 3'd5, 16'h0008, 16'h0100, 0, 1, "br_abs", 16'h0008);
        step(0, 1, 3'd2, 16'h0010, 0, 0, 0, "setpc", 16'h0010);
        step(0, 1, 3'd6, 16'h0008, 16'h0100, 0, 1, "br_ra", 16'h0100);
        step(0, 1, 3'd2, 16'h0010, 0, 0, 0, "setpc", 16'h0010);
        step(0, 1, 3'd1, 16'hFFF8, 16'h0100, 0, 1, "br_neg", 16'h0008);

        step(0, 1, 3'd2, 16'hFFFE, 0, 0, 0, "setpc", 16'hFFFE);
        step(0, 1, 3'd0, 16'h0000, 0, 0, 0, "wrap", 16'h0000);
        step(0, 1, 3'd2, 16'hFFFE, 0, 0, 1, "setpc", 16'hFFFE);
        step(0, 1, 3'd1, 16'h0004, 0, 0, 1, "wrap_rel", 16'h0002);

        step(1, 1, 3'd2, 16'h00AA, 0, 0, 0, "prio_rst", 16'h0000);
        step(0, 1, 3'd2, 16'h00AA, 0, 0, 0, "prio_rel", 16'h00AA);

        // Randomized traffic; the negedge compare process checks every cycle.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            reset   = ($urandom_range(0, 31) == 0);
            pcWrite = ($urandom_range(0, 3) != 0);
            pcSrc   = 3'($urandom_range(0, 7));
            immAddr = 16'($urandom);
            ra      = 16'($urandom);
            mary    = 16'($urandom);
            comp    = 1'($urandom);
            if (i % 250 == 0)
                $display("txn random #%0d rst=%0d wr=%0d src=%0d pcOut=%h", i, reset, pcWrite, pcSrc, pcOut);
        end
        @(negedge clock);
        reset = 1'b0; pcWrite = 1'b0;
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
